// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine holding the architectural HI/LO pair.
// Shift-add multiply and restoring divide, one bit per cycle, sign-fixed in a final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [1:0]         op_q;
    logic               sign_a_q, sign_b_q, dz_q;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   low_q, low_d;
    logic [WIDTH-1:0]   opnd_q;

    logic               accept;
    logic               op_signed;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shl;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_res, rem_res;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign accept    = (state_q == S_IDLE) && start;
    assign op_signed = ~op[0];
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    // One iteration: acc_q is the running partial (product high half or remainder),
    // low_q shifts out multiplier bits or shifts in quotient bits.
    always_comb begin
        acc_d   = acc_q;
        low_d   = low_q;
        mul_sum = {1'b0, acc_q} + {1'b0, (low_q[0] ? opnd_q : '0)};
        div_shl = {acc_q, low_q[WIDTH-1]};
        div_ge  = (div_shl >= {1'b0, opnd_q});
        if (op_q[1]) begin
            acc_d = div_ge ? (div_shl[WIDTH-1:0] - opnd_q) : div_shl[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = mul_sum[WIDTH:1];
            low_d = {mul_sum[0], low_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        mul_res = cond_neg2({acc_q, low_q}, ~op_q[0] & (sign_a_q ^ sign_b_q));
        quo_res = dz_q ? '1 : cond_neg(low_q, ~op_q[0] & (sign_a_q ^ sign_b_q));
        rem_res = cond_neg(acc_q, ~op_q[0] & sign_a_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d = S_ITER;
                    cnt_d   = '0;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end else begin
                    hi_d = mul_res[2*WIDTH-1:WIDTH];
                    lo_d = mul_res[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Operand capture: divide keeps the dividend in low_q and the divisor in opnd_q,
    // multiply keeps the multiplier in low_q and the multiplicand in opnd_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= op;
            sign_a_q <= op_signed & rs_data[WIDTH-1];
            sign_b_q <= op_signed & rt_data[WIDTH-1];
            dz_q     <= (rt_data == '0);
            acc_q    <= '0;
            if (op[1]) begin
                opnd_q <= magnitude(rt_data, op_signed);
                low_q  <= magnitude(rs_data, op_signed);
            end else begin
                opnd_q <= magnitude(rs_data, op_signed);
                low_q  <= magnitude(rt_data, op_signed);
            end
        end else if (state_q == S_ITER) begin
            acc_q <= acc_d;
            low_q <= low_d;
        end
    end

endmodule
